// File: rtl/wave_sample_scheduler.sv
// -----------------------------------------------------------------------------
// wave_sample_scheduler
//
// Sample-rate scheduler and mixer for the waveform generator. A divider turns
// clk_in into a one-cycle sample strobe (tick). On each tick in IDLE the block
// latches the channel enable mask, fetches one sample from every enabled
// channel through a single shared req/ack read port, sums the samples, and
// offers the mix downstream on a valid/ready handshake.
//
// Parameters:
//   DIV     clk_in cycles per sample strobe (2..65535), default 250 (48 kHz @ 12 MHz)
//   NUM_CH  number of waveform channels (1..8)
//   SW      sample width, signed two's complement
//
// Ports:
//   clk_in     in   system clock
//   reset_n    in   asynchronous active-low reset
//   ch_en      in   channel enable mask, captured at the frame-start tick
//   gen_req    out  fetch request to the shared generator read port
//   gen_ch     out  channel index of the current fetch
//   gen_ack    in   generator has placed gen_data for gen_ch
//   gen_data   in   signed sample, valid while gen_ack=1
//   out_data   out  mixed sample (0 when out_valid=0)
//   out_valid  out  out_data is valid; held until accepted
//   out_ready  in   downstream accepts out_data
//   tick       out  one-cycle sample strobe
//   busy       out  a frame is in progress
//   overrun    out  sticky: a tick arrived while busy (cleared only by reset)
//
// Build option:
//   WAVE_MIX_SAT_EN  when defined, the sum is clamped to the SW-bit signed
//                    range; otherwise it wraps (low SW bits are used).
// -----------------------------------------------------------------------------
module wave_sample_scheduler #(
    parameter int DIV    = 250,
    parameter int NUM_CH = 4,
    parameter int SW     = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic                 gen_req,
    output logic [2:0]           gen_ch,
    input  logic                 gen_ack,
    input  logic signed [SW-1:0] gen_data,
    output logic signed [SW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 tick,
    output logic                 busy,
    output logic                 overrun
);

    // Three guard bits hold the sum of up to eight full-scale samples.
    localparam int AW = SW + 3;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [15:0]           div_cnt_q;
    logic [3:0]            idx_q;
    logic signed [AW-1:0]  acc_q;
    logic [NUM_CH-1:0]     en_q;
    logic                  scan_hit;
    logic [2:0]            scan_ch;
    logic signed [SW-1:0]  mix;

    // ---------------------------------------------------------------- divider
    assign tick = (div_cnt_q == 16'(DIV - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------ channel search
    // Lowest enabled channel at or above idx; iterating downwards lets the
    // last (lowest) match win.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en_q[i] && (4'(i) >= idx_q)) begin
                scan_hit = 1'b1;
                scan_ch  = 3'(i);
            end
        end
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (tick)                   state_d = S_SCAN;
            S_SCAN:   state_d = scan_hit ? S_FETCH : S_OUTPUT;
            S_FETCH:  if (gen_ack)                state_d = S_SCAN;
            S_OUTPUT: if (out_valid && out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            gen_ch  <= '0;
            overrun <= 1'b0;
        end else begin
            // A tick outside IDLE is dropped and recorded.
            if (tick && (state_q != S_IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        en_q  <= ch_en;
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        gen_ch <= scan_ch;
                    end
                end
                S_FETCH: begin
                    if (gen_ack) begin
                        acc_q <= acc_q + {{3{gen_data[SW-1]}}, gen_data};
                        idx_q <= {1'b0, gen_ch} + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------- mix reduction
`ifdef WAVE_MIX_SAT_EN
    // The sum fits in SW bits only when the guard bits all equal its sign.
    always_comb begin
        if (acc_q[AW-1:SW-1] == '0 || acc_q[AW-1:SW-1] == '1) begin
            mix = acc_q[SW-1:0];
        end else if (acc_q[AW-1]) begin
            mix = {1'b1, {(SW-1){1'b0}}};
        end else begin
            mix = {1'b0, {(SW-1){1'b1}}};
        end
    end
`else
    assign mix = acc_q[SW-1:0];
`endif

    // --------------------------------------------------------------- outputs
    always_comb begin
        gen_req   = (state_q == S_FETCH);
        out_valid = (state_q == S_OUTPUT);
        busy      = (state_q != S_IDLE);
        out_data  = (state_q == S_OUTPUT) ? mix : '0;
    end

endmodule

// File: doc/wave_sample_scheduler.md
# wave_sample_scheduler

Sample-rate scheduler and mixer for the waveform generator. It derives a one-cycle sample strobe from the 12 MHz clock, defaulting to 48 kHz. On each strobe it fetches one sample from each enabled waveform channel over a req/ack handshake through a single shared read port, sums the samples, and presents the mixed sample to the downstream DAC/I2S interface on a valid/ready handshake. It replaces free-running per-channel clocks with one scheduler that owns sample timing.

## Interface
Parameters:
- DIV, 250: clk_in cycles per sample strobe (12 MHz / 250 = 48 kHz); legal range 2..65535.
- NUM_CH, 4: number of waveform channels; legal range 1..8.
- SW, 16: sample width, signed two's complement.

Ports:
- clk_in  in  1  system clock, 12 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  channel enable mask, sampled once per frame at the strobe.
- gen_req  out  1  fetch request to the shared generator read port.
- gen_ch  out  3  channel index for the current fetch.
- gen_ack  in  1  generator has placed gen_data for gen_ch.
- gen_data  in  SW  signed sample, valid while gen_ack=1.
- out_data  out  SW  mixed sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- tick  out  1  one-cycle sample strobe.
- busy  out  1  a frame is in progress (state != IDLE).
- overrun  out  1  sticky flag: a strobe arrived while busy.

## Operation
- Divider: a 16-bit counter runs 0..DIV-1 and then wraps to 0. tick=1 in the cycle when the counter equals DIV-1.
- Frame start: on tick in IDLE, the block latches ch_en into en_q, clears the accumulator, sets idx=0, and enters SCAN.
- SCAN: selects the lowest index ≥ idx whose en_q bit is set.
  - If such an index exists, gen_ch takes that index and the block enters FETCH.
  - Otherwise the block enters OUTPUT.
- FETCH: gen_req=1 while gen_ch is held stable.
  - When gen_ack=1, the block adds sign-extended gen_data to the accumulator (width SW+3), deasserts gen_req in the next cycle, sets idx=gen_ch+1, and returns to SCAN.
  - gen_ack arriving while gen_req=0 is ignored.
- OUTPUT: out_data holds the clamped or truncated sum (see Configuration), and out_valid=1.
  - When out_valid and out_ready are both 1, the block returns to IDLE.
  - out_data and out_valid stay stable until accepted.
- All channels disabled: the frame still produces out_data=0 with out_valid=1.
- Overrun: a tick while busy sets overrun=1. That tick is dropped, the current frame continues, and overrun is cleared only by reset.
- ch_en changes mid-frame have no effect until the next frame.

## Timing
- Reset values:
  - Counter, idx, accumulator, en_q: 0. The counter restarts from 0.
  - State: IDLE.
  - gen_req=0, gen_ch=0, out_data=0, out_valid=0, tick=0, busy=0, overrun=0.
- The first tick occurs DIV cycles after reset_n deasserts, then every DIV cycles.
- Tick to first gen_req = 2 cycles: tick→SCAN, SCAN→FETCH.
- Each fetch costs 2 cycles (SCAN + FETCH) plus the ack wait. A zero-wait ack lands in the cycle after gen_req rises.
- Last ack to out_valid = 2 cycles.
- Minimum frame with all channels enabled and zero-wait handshakes: 3×NUM_CH+3 cycles. This must be below DIV for overrun-free operation.
- Reset asserted mid-frame aborts the frame immediately. No out_valid is emitted.
- Simultaneous tick and out_valid&&out_ready in OUTPUT: the handshake completes, the tick counts as an overrun, and no frame starts.

## Configuration
- WAVE_MIX_SAT_EN defined: the accumulator is clamped to [-2^(SW-1), 2^(SW-1)-1] before driving out_data.
- Undefined: out_data = accumulator[SW-1:0] (two's-complement wrap) and the clamp logic is absent.

## Test plan
- DIV=250, NUM_CH=4, ch_en=4'b1111, gen_ack one cycle after gen_req, gen_data = 100, 200, 300, 400 -> gen_ch sequence 0,1,2,3; out_data=1000; tick period 250 cycles; overrun=0.
- ch_en=4'b1010, out_ready=1 -> only gen_ch 1 and 3 are requested, and out_data is their sum; ch_en=0 -> out_data=0 and out_valid pulses once per frame.
- SW=16, four samples of 16000 -> 32767 with WAVE_MIX_SAT_EN, -1536 without it. Four samples of -16000 -> -32768 with WAVE_MIX_SAT_EN.
- out_ready held 0 for 300 cycles -> out_valid/out_data stay stable, overrun=1 at the next tick, and the frame is accepted once out_ready=1.
- gen_ack stalled 10 cycles -> gen_req/gen_ch stay stable; a spurious gen_ack with gen_req=0 leaves the sum unchanged.
- reset_n pulsed low during FETCH -> all outputs reset asynchronously; the next tick occurs exactly DIV cycles after release.
